// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Latency: DATA_WIDTH+1 cycles for normal ops, 1 cycle for div-by-zero/overflow (and multiplies when fast).
// Backpressure: none; busy_o stalls the pipeline, start_i is ignored while busy_o=1.
//
// Ports: clk_i/rst_ni (async active-low), start_i + op_i (funct3) + srcA_i/srcB_i launch an op,
//        flush_i aborts any op in flight, busy_o = op in flight, valid_o = one-cycle result strobe,
//        result_o holds the last result until the next valid_o.
// Optional feature: define MULDIV_FAST_MUL_EN for single-cycle multiplies using a multiply operator.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]           state_q;
  logic [2:0]           op_q;
  logic [W-1:0]         opnd_q;   // multiplicand (mul) or divisor (div), magnitude
  logic [2*W-1:0]       acc_q;    // mul: {hi, lo/multiplier}; div: {rem, quot}
  logic                 neg_q;    // negate the magnitude result in FIX
  logic [CNT_WIDTH-1:0] cnt_q;

  // ---------------- launch decode (IDLE only) ----------------
  logic         is_div_in;
  logic         sign_a_in;
  logic         sign_b_in;
  logic         neg_a;
  logic         neg_b;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;
  logic         div_zero;
  logic         div_ovf;

  always_comb begin
    is_div_in = op_i[2];
    // Div side: even funct3 is signed. Mul side: only MULHU has unsigned A, MULHSU/MULHU unsigned B.
    sign_a_in = is_div_in ? ~op_i[0] : (op_i[1:0] != 2'b11);
    sign_b_in = is_div_in ? ~op_i[0] : ~op_i[1];
    neg_a     = sign_a_in & srcA_i[W-1];
    neg_b     = sign_b_in & srcB_i[W-1];
    abs_a     = neg_a ? (~srcA_i + 1'b1) : srcA_i;
    abs_b     = neg_b ? (~srcB_i + 1'b1) : srcB_i;
    div_zero  = is_div_in & (srcB_i == '0);
    div_ovf   = is_div_in & ~op_i[0] & (srcA_i == {1'b1, {(W-1){1'b0}}}) & (srcB_i == '1);
  end

  // ---------------- optional single-cycle multiplier ----------------
  logic [2*W-1:0] fast_prod;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic [2*W+1:0] fast_a;
  logic [2*W+1:0] fast_b;
  logic [2*W+1:0] fast_full;
  always_comb begin
    // Sign- or zero-extend to 2W+2 bits; the truncated unsigned product is the exact signed product.
    fast_a    = {{(W+2){sign_a_in & srcA_i[W-1]}}, srcA_i};
    fast_b    = {{(W+2){sign_b_in & srcB_i[W-1]}}, srcB_i};
    fast_full = fast_a * fast_b;
    fast_prod = fast_full[2*W-1:0];
  end
`else
  localparam bit FastMul = 1'b0;
  assign fast_prod = '0;
`endif

  // ---------------- one iteration step ----------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_next;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right
    // with the carry entering the top.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    // Divide: shifted remainder needs W+1 bits since it can reach 2*divisor-1.
    div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
  end

  // ---------------- sign fix-up and output select ----------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_fix  = neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    fix_res  = prod_fix[W-1:0];
    case (op_q)
      3'b000:                 fix_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // ---------------- FSM and datapath registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              op_q   <= op_i;
              opnd_q <= is_div_in ? abs_b : abs_a;
              cnt_q  <= CNT_WIDTH'(W-1);
              // Remainder takes the dividend's sign; products and quotients take signA^signB.
              neg_q  <= (is_div_in & op_i[1]) ? neg_a : (neg_a ^ neg_b);
              if (div_zero) begin
                // Preloaded as {rem, quot} so the normal FIX select picks the right value.
                acc_q   <= {srcA_i, {W{1'b1}}};
                neg_q   <= 1'b0;
                state_q <= ST_FIX;
              end else if (div_ovf) begin
                acc_q   <= {{W{1'b0}}, srcA_i};
                neg_q   <= 1'b0;
                state_q <= ST_FIX;
              end else if (FastMul && !is_div_in) begin
                acc_q   <= fast_prod;
                neg_q   <= 1'b0;
                state_q <= ST_FIX;
              end else begin
                acc_q   <= is_div_in ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
                state_q <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            result_o <= fix_res;
            valid_o  <= 1'b1;
            state_q  <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus hand sequences for flush, ignored start and reset.
// Latency: measured in clock edges after the start edge.
// Backpressure: none; the bench waits on valid_o with a bounded cycle budget.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] srcA_i = '0;
  logic [31:0] srcB_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .op_i    (op_i),
    .srcA_i  (srcA_i),
    .srcB_i  (srcB_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op from an idle cycle (called #1 after an edge) and wait for valid_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok);
    logic got;
    op_i = op; srcA_i = a; srcB_i = b; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    lat = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (valid_o) got = 1'b1;
      else if (!busy_o) busy_ok = 1'b0;
    end
    if (!got) lat = -1;
    res = result_o;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    int          lat;
    logic        busy_ok;
    int          nvalid;
    logic        got;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT};
    vecs[5]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
    vecs[6]  = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT};
    vecs[7]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT};
    vecs[8]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT};
    vecs[9]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT};
    vecs[10] = '{3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT};
    vecs[11] = '{3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT};
    vecs[12] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
    vecs[13] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT};
    vecs[14] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT};
    vecs[15] = '{3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, DIV_LAT};
    vecs[16] = '{3'b100, 32'h80000000, 32'd1,        32'h80000000, DIV_LAT};
    vecs[17] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT};
    vecs[18] = '{3'b110, 32'd5,        32'd0,        32'h00000005, SPC_LAT};
    vecs[19] = '{3'b111, 32'd9,        32'd0,        32'h00000009, SPC_LAT};
    vecs[20] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT};
    vecs[21] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPC_LAT};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // Table of ops; each launches in the valid cycle of the previous one (back-to-back).
    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_ok);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_before_valid", i), {31'd0, busy_ok}, 32'd1);
      check($sformatf("vec%0d_busy_at_valid", i), {31'd0, busy_o}, 32'd0);
    end

    // Flush 10 cycles into a DIVU: no valid, result unchanged.
    @(posedge clk_i);
    #1;
    prev = result_o;
    op_i = 3'b101; srcA_i = 32'd100; srcB_i = 32'd7; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("busy_mid_divu", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_result_held", result_o, prev);
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) nvalid++;
    end
    check("flush_no_valid", nvalid, 0);

    // start together with flush in IDLE is dropped.
    op_i = 3'b000; srcA_i = 32'd3; srcB_i = 32'd4; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", {31'd0, busy_o}, 32'd0);
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) nvalid++;
    end
    check("flush_start_no_valid", nvalid, 0);
    check("flush_start_result_held", result_o, prev);

    // start pulsed while busy with different operands is ignored.
    op_i = 3'b101; srcA_i = 32'd100; srcB_i = 32'd7; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (lat == 5) begin
        op_i = 3'b000; srcA_i = 32'd3; srcB_i = 32'd4; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (valid_o) got = 1'b1;
    end
    if (!got) lat = -1;
    check("busy_start_result", result_o, 32'd14);
    check("busy_start_latency", lat, DIV_LAT);
    @(posedge clk_i);
    #1;
    check("valid_one_cycle", {31'd0, valid_o}, 32'd0);
    check("result_holds", result_o, 32'd14);
    check("ignored_start_not_run", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset mid-CALC.
    op_i = 3'b101; srcA_i = 32'd100; srcB_i = 32'd7; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    run_op(3'b000, 32'd3, 32'd4, res, lat, busy_ok);
    check("post_rst_mul_result", res, 32'd12);
    check("post_rst_mul_latency", lat, MUL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. It shares the srcA/srcB operand buses with the ALU, and its result is muxed with ALUResult ahead of the EX/MEM register. The hazard unit stalls the pipeline while busy_o is high. The unit implements all eight M-extension ops (funct3-encoded) with a radix-2 shift-add multiplier and a restoring divider.

## Interface
- DATA_WIDTH, 32, operand/result width (W)
- CNT_WIDTH, 5, iteration counter width, $clog2(DATA_WIDTH)
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous, active-low reset
- start_i  input  1  launch op; sampled only when busy_o=0
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcA_i  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
- srcB_i  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
- flush_i  input  1  synchronous abort (branch mispredict/trap)
- busy_o  output  1  op in flight; high in CALC and FIX
- valid_o  output  1  one-cycle result strobe
- result_o  output  DATA_WIDTH  result; holds until next valid_o

## Operation
- FSM states are IDLE, CALC, FIX. busy_o = (state != IDLE).
- **IDLE, start_i=1:**
  - Latch op_i.
  - Latch |srcA_i| and |srcB_i| according to signedness: A is signed for MUL/MULH/MULHSU/DIV/REM; B is signed for MUL/MULH/DIV/REM.
  - Record the result sign: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
  - Load counter = W-1 and go to CALC.
- **CALC, multiply:** each cycle, if multiplier LSB=1, add the multiplicand into the upper half of the 2W product register, then shift right 1.
- **CALC, divide:** each cycle, shift {rem,quot} left 1 and trial-subtract the divisor. If non-negative, keep the difference and set quot LSB.
- **CALC exit:** when counter==0 after an iteration, go to FIX. The counter decrements once per CALC cycle.
- **FIX:**
  - Negate if the sign flag is set, then select the output: MUL gives the low W; MULH/MULHSU/MULHU give the high W; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register result_o, pulse valid_o, return to IDLE.
- **Special cases:** detected in IDLE at start; the unit goes IDLE→FIX directly and skips CALC.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give srcA_i.
  - Signed overflow (DIV/REM with srcA_i=0x80000000, srcB_i=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **start_i while busy_o=1:** ignored. Operands are not re-latched.
- **flush_i:**
  - Any state → IDLE at the next edge. No valid_o, result_o unchanged.
  - flush_i has priority over start_i in the same cycle; that start is dropped.
- **Reset (any time, including mid-CALC):** state=IDLE, busy_o=0, valid_o=0, result_o=0, internal registers=0.

## Timing
- Start is sampled at edge 0.
- Normal op: edges 1..W are the CALC iterations. At edge W+1 the FSM is in FIX and result_o/valid_o are registered. valid_o is high during the cycle after edge W+1, so latency is W+1 cycles (33 for W=32).
- Special cases: FIX at edge 1; valid_o is high in the cycle after edge 1, so latency is 1.
- valid_o lasts exactly one cycle. State is IDLE (busy_o=0) in that same cycle, so back-to-back start is allowed there.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU compute the full 2W signed-extended product with a single multiply operator and go IDLE→FIX.
  - Latency is 1 cycle.
  - Divide ops are unchanged.
- MULDIV_FAST_MUL_EN undefined: multiplies use the iterative path with latency W+1, and no multiply operator is inferred.

## Test plan
- **Multiply latency:** MUL 7 × 0xFFFFFFFD (−3) → result_o=0xFFFFFFEB. valid_o arrives 33 cycles after the start edge (1 cycle with MULDIV_FAST_MUL_EN), and busy_o is high for 32 cycles before it.
- **High-half multiplies, both operands 0xFFFFFFFF:** MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF; MUL → 0x00000001.
- **Divide signs:**
  - DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD.
  - REM −7,2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2. Each takes 33 cycles.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All four have 1-cycle latency.
- **Flush and ignored start:**
  - Assert flush_i 10 cycles into a DIVU → busy_o=0 next cycle, no valid_o, result_o keeps its previous value.
  - start_i in the same cycle as flush_i → ignored.
  - start_i pulsed while busy with different operands → ignored; the original result is delivered.
- **Reset mid-op:** drop rst_ni during CALC → busy_o, valid_o and result_o go to 0 immediately (asynchronously). After release, a fresh MUL 3×4 → 12 with nominal latency.
